// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive ring.
package eth_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DROP, COMMIT} rx_ring_state_e;

  localparam logic [47:0] ETH_BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [23:0] ETH_MCAST_OUI = 24'h01005E;

  // Widest length field over the legal BUF_BYTES range (4096 -> 13 bits).
  localparam int LEN_MAX_W = 13;

  typedef struct packed {
    logic                 err;
    logic                 trunc;
    logic [LEN_MAX_W-1:0] len;
  } rx_len_entry_t;

endpackage

// File: rtl/eth_rx_addr_filter.sv
// Destination MAC acceptance: own address, broadcast, IPv4 multicast or promiscuous.
module eth_rx_addr_filter
  import eth_pkg::*;
(
  input  logic [47:0] dest_i,
  input  logic [47:0] mac_addr_i,
  input  logic        promisc_i,
  output logic        match_o
);

  assign match_o = promisc_i
                 | (dest_i == mac_addr_i)
                 | (dest_i == ETH_BCAST)
                 | (dest_i[47:24] == ETH_MCAST_OUI);

endmodule

// File: rtl/eth_rx_ring.sv
// Receive-buffer ring controller: steers frames into NBUF packet-RAM slots.
// Build option ETH_RX_ERR_DROP_EN: reject and count frames ending with rx_tuser.
module eth_rx_ring
  import eth_pkg::*;
#(
  parameter int NBUF      = 8,
  parameter int BUF_BYTES = 2048,
  parameter int LEN_W     = $clog2(BUF_BYTES) + 1,
  parameter int DROP_W    = 16
) (
  input  logic                              msoc_clk,
  input  logic                              rst_int_n,
  input  logic [7:0]                        rx_tdata,
  input  logic                              rx_tvalid,
  input  logic                              rx_tlast,
  input  logic                              rx_tuser,
  input  logic [47:0]                       mac_addr,
  input  logic                              promiscuous,
  input  logic                              irq_en,
  input  logic [$clog2(NBUF):0]             irq_thresh,
  input  logic                              cons_we,
  input  logic [$clog2(NBUF):0]             cons_wdata,
  input  logic [$clog2(NBUF)-1:0]           len_idx,
  output logic [LEN_W+1:0]                  len_rdata,
  output logic                              ram_we,
  output logic [$clog2(NBUF*BUF_BYTES)-1:0] ram_waddr,
  output logic [7:0]                        ram_wdata,
  output logic [$clog2(NBUF):0]             prod_idx,
  output logic [$clog2(NBUF):0]             cons_idx,
  output logic [$clog2(NBUF):0]             pending,
  output logic [DROP_W-1:0]                 drop_cnt,
  output logic                              irq
);

  localparam int SW = $clog2(NBUF);
  localparam int IW = SW + 1;
  localparam int OW = $clog2(BUF_BYTES);
  localparam int AW = SW + OW;

`ifdef ETH_RX_ERR_DROP_EN
  localparam bit ERR_DROP = 1'b1;
`else
  localparam bit ERR_DROP = 1'b0;
`endif

  rx_ring_state_e    state_q;
  logic [LEN_W-1:0]  off_q;
  logic [47:0]       dest_q;
  logic              trunc_q;
  logic [SW-1:0]     slot_q;
  rx_len_entry_t     commit_q;
  logic [IW-1:0]     prod_q, cons_q;
  logic [DROP_W-1:0] drop_q;
  logic              irq_q;
  logic              ram_we_q;
  logic [AW-1:0]     ram_waddr_q;
  logic [7:0]        ram_wdata_q;
  logic [LEN_W+1:0]  len_mem_q [NBUF];

  logic [IW-1:0]     prod_d, cons_d, pend_cur, pend_post, cons_delta, thr;
  logic [LEN_W-1:0]  off_inc;
  logic [47:0]       dest_nxt;
  logic [DROP_W-1:0] drop_inc;
  logic              full, at_trunc, len_ok, match;

  assign pend_cur   = prod_q - cons_q;
  assign cons_delta = cons_wdata - cons_q;

  // Consumer may only retire slots the producer has already filled.
  always_comb begin
    cons_d = cons_q;
    if (cons_we && (cons_delta <= pend_cur)) cons_d = cons_wdata;
  end

  assign prod_d    = (state_q == COMMIT) ? prod_q + IW'(1) : prod_q;
  assign pend_post = prod_d - cons_d;
  assign full      = (pend_post == IW'(NBUF));
  assign thr       = (irq_thresh == '0) ? IW'(1) : irq_thresh;

  assign off_inc   = (&off_q) ? off_q : off_q + LEN_W'(1);
  assign at_trunc  = (off_q >= LEN_W'(BUF_BYTES));
  assign len_ok    = (off_inc >= LEN_W'(6));
  assign dest_nxt  = (off_q < LEN_W'(6)) ? {dest_q[39:0], rx_tdata} : dest_q;
  assign drop_inc  = (&drop_q) ? drop_q : drop_q + DROP_W'(1);

  eth_rx_addr_filter u_filt (
    .dest_i     (dest_nxt),
    .mac_addr_i (mac_addr),
    .promisc_i  (promiscuous),
    .match_o    (match)
  );

  always_ff @(posedge msoc_clk) begin
    if (!rst_int_n) begin
      state_q     <= IDLE;
      off_q       <= '0;
      dest_q      <= '0;
      trunc_q     <= 1'b0;
      slot_q      <= '0;
      commit_q    <= '0;
      prod_q      <= '0;
      cons_q      <= '0;
      drop_q      <= '0;
      irq_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      prod_q   <= prod_d;
      cons_q   <= cons_d;
      irq_q    <= irq_en & (pend_post >= thr);
      ram_we_q <= 1'b0;
      case (state_q)
        // COMMIT doubles as IDLE so a back-to-back frame is not lost.
        IDLE, COMMIT: begin
          state_q <= IDLE;
          if (rx_tvalid) begin
            if (full) begin
              if (rx_tlast) drop_q  <= drop_inc;
              else          state_q <= DROP;
            end else begin
              ram_we_q    <= 1'b1;
              ram_waddr_q <= {prod_d[SW-1:0], {OW{1'b0}}};
              ram_wdata_q <= rx_tdata;
              slot_q      <= prod_d[SW-1:0];
              off_q       <= LEN_W'(1);
              dest_q      <= {40'h0, rx_tdata};
              trunc_q     <= 1'b0;
              if (!rx_tlast) state_q <= RECV;
            end
          end
        end
        RECV: begin
          if (rx_tvalid) begin
            if (!at_trunc) begin
              ram_we_q    <= 1'b1;
              ram_waddr_q <= {slot_q, off_q[OW-1:0]};
              ram_wdata_q <= rx_tdata;
            end
            off_q   <= off_inc;
            dest_q  <= dest_nxt;
            trunc_q <= trunc_q | at_trunc;
            if (rx_tlast) begin
              state_q <= IDLE;
              if (ERR_DROP && rx_tuser) begin
                drop_q <= drop_inc;
              end else if (len_ok && match) begin
                state_q        <= COMMIT;
                commit_q.err   <= rx_tuser;
                commit_q.trunc <= trunc_q | at_trunc;
                commit_q.len   <= LEN_MAX_W'(off_inc);
              end
            end
          end
        end
        DROP: begin
          if (rx_tvalid && rx_tlast) begin
            drop_q  <= drop_inc;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Length table is not reset; entries are valid once committed.
  always_ff @(posedge msoc_clk) begin
    if (rst_int_n && state_q == COMMIT)
      len_mem_q[prod_q[SW-1:0]] <= {commit_q.err, commit_q.trunc, commit_q.len[LEN_W-1:0]};
  end

  assign len_rdata = len_mem_q[len_idx];
  assign ram_we    = ram_we_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign prod_idx  = prod_q;
  assign cons_idx  = cons_q;
  assign pending   = pend_cur;
  assign drop_cnt  = drop_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_eth_rx_ring.sv
// Randomized bench for eth_rx_ring against a frame-level reference model.
module tb_eth_rx_ring;

  localparam int NB   = 8;
  localparam int BUFB = 2048;

`ifdef ETH_RX_ERR_DROP_EN
  localparam bit ERR_DROP = 1'b1;
`else
  localparam bit ERR_DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid, rx_tlast, rx_tuser;
  logic [47:0] mac_addr;
  logic        promiscuous, irq_en;
  logic [3:0]  irq_thresh;
  logic        cons_we;
  logic [3:0]  cons_wdata;
  logic [2:0]  len_idx;
  logic [13:0] len_rdata;
  logic        ram_we;
  logic [13:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic [3:0]  prod_idx, cons_idx, pending;
  logic [15:0] drop_cnt;
  logic        irq;

  always #5 clk = ~clk;

  eth_rx_ring dut (
    .msoc_clk(clk), .rst_int_n(rst_n),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .mac_addr(mac_addr), .promiscuous(promiscuous), .irq_en(irq_en), .irq_thresh(irq_thresh),
    .cons_we(cons_we), .cons_wdata(cons_wdata), .len_idx(len_idx), .len_rdata(len_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .prod_idx(prod_idx), .cons_idx(cons_idx), .pending(pending),
    .drop_cnt(drop_cnt), .irq(irq)
  );

  int          n_vec = 0, n_err = 0;
  int          m_prod, m_cons, m_drop;
  logic [13:0] m_len [NB];
  bit          m_vld [NB];
  logic [21:0] exp_q[$], got_q[$];
  logic [7:0]  fb [2200];

  always @(negedge clk) if (ram_we) got_q.push_back({ram_waddr, ram_wdata});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0; cons_we = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_prod = 0; m_cons = 0; m_drop = 0;
    for (int i = 0; i < NB; i++) m_vld[i] = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  // kind: 0 own MAC, 1 broadcast, 2 IPv4 multicast, 3 foreign unicast
  task automatic build(input int kind, input int n);
    logic [47:0] d;
    case (kind)
      0:       d = mac_addr;
      1:       d = 48'hFFFF_FFFF_FFFF;
      2:       d = {24'h01005E, 24'($urandom)};
      default: d = {8'h02, 40'($urandom)};
    endcase
    for (int i = 0; i < n; i++) fb[i] = (i < 6) ? d[47-8*i -: 8] : 8'($urandom);
  endtask

  task automatic send_frame(input int n, input bit tuser, input bit cw, input int cwd);
    int pend, slot;
    logic [47:0] d;
    bit hit;
    pend = (m_prod - m_cons) & 15;
    if (pend == NB) begin
      m_drop++;
    end else begin
      slot = m_prod % NB;
      for (int i = 0; i < n && i < BUFB; i++) exp_q.push_back({3'(slot), 11'(i), fb[i]});
      d   = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
      hit = promiscuous || d == mac_addr || d == 48'hFFFF_FFFF_FFFF || d[47:24] == 24'h01005E;
      if (n >= 2) begin
        if (ERR_DROP && tuser) m_drop++;
        else if (n >= 6 && hit) begin
          m_len[slot] = {tuser, n > BUFB, 12'((n > 4095) ? 4095 : n)};
          m_vld[slot] = 1'b1;
          m_prod      = (m_prod + 1) & 15;
        end
      end
    end
    if (cw && (((cwd - m_cons) & 15) <= pend)) m_cons = cwd & 15;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin rx_tvalid = 1'b0; tick(); end
      rx_tvalid = 1'b1; rx_tdata = fb[i]; rx_tlast = (i == n - 1);
      rx_tuser  = (i == n - 1) ? tuser : 1'($urandom);
      tick();
    end
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    if (cw) begin
      cons_we = 1'b1; cons_wdata = 4'(cwd); tick(); cons_we = 1'b0;
    end
  endtask

  task automatic cons_write(input int v);
    if (((v - m_cons) & 15) <= ((m_prod - m_cons) & 15)) m_cons = v & 15;
    cons_we = 1'b1; cons_wdata = 4'(v); tick(); cons_we = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int pend, thr, bad;
    repeat (3) tick();
    pend = (m_prod - m_cons) & 15;
    thr  = (irq_thresh == 0) ? 1 : int'(irq_thresh);
    chk({tag, ":prod"},    prod_idx, m_prod);
    chk({tag, ":cons"},    cons_idx, m_cons);
    chk({tag, ":pending"}, pending,  pend);
    chk({tag, ":drop"},    drop_cnt, m_drop);
    chk({tag, ":irq"},     irq,      irq_en && pend >= thr);
    chk({tag, ":nwr"},     got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, ":wrdata"}, bad, 0);
    got_q.delete(); exp_q.delete();
    for (int s = 0; s < NB; s++) begin
      if (m_vld[s]) begin
        len_idx = 3'(s); #1;
        chk({tag, ":len"}, len_rdata, m_len[s]);
      end
    end
  endtask

  initial begin
    rx_tdata = '0; rx_tuser = 1'b0; mac_addr = 48'h0A1B_2C3D_4E5F;
    promiscuous = 1'b0; irq_en = 1'b0; irq_thresh = '0; cons_wdata = '0; len_idx = '0;
    tick();
    do_reset();
    chk("rst:prod", prod_idx, 0); chk("rst:cons", cons_idx, 0);
    chk("rst:pending", pending, 0); chk("rst:drop", drop_cnt, 0);
    chk("rst:irq", irq, 0); chk("rst:we", ram_we, 0);

    irq_en = 1'b1; irq_thresh = 4'd1;
    build(0, 64); send_frame(64, 1'b0, 1'b0, 0); check_state("ucast64");

    build(3, 40); fb[0] = 8'h02; fb[1] = 8'h00; fb[2] = 8'h00;
    fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h99;
    send_frame(40, 1'b0, 1'b0, 0); check_state("foreign");
    promiscuous = 1'b1; send_frame(40, 1'b0, 1'b0, 0); check_state("promisc");
    promiscuous = 1'b0;

    for (int i = 0; i < 6; i++) begin build(0, 20 + i); send_frame(20 + i, 1'b0, 1'b0, 0); end
    check_state("fill");
    build(1, 30); send_frame(30, 1'b0, 1'b0, 0); check_state("full_drop");
    cons_write(1); check_state("cons1");
    build(2, 30); send_frame(30, 1'b0, 1'b0, 0); check_state("after_free");

    cons_write(m_prod); check_state("drain");
    build(0, 2100); send_frame(2100, 1'b0, 1'b0, 0); check_state("trunc");
    build(0, 64); send_frame(64, 1'b1, 1'b0, 0); check_state("tuser");

    cons_write(m_prod);
    for (int i = 0; i < 2; i++) begin build(1, 12); send_frame(12, 1'b0, 1'b0, 0); end
    cons_write((m_cons + 5) & 15); check_state("cons_ovtk");
    build(0, 16); send_frame(16, 1'b0, 1'b1, (m_cons + 1) & 15); check_state("coincident");

    build(0, 50);
    for (int i = 0; i < 20; i++) begin
      rx_tvalid = 1'b1; rx_tdata = fb[i]; rx_tlast = 1'b0; tick();
    end
    do_reset();
    chk("midrst:prod", prod_idx, 0); chk("midrst:cons", cons_idx, 0);
    chk("midrst:drop", drop_cnt, 0);
    build(0, 50); send_frame(50, 1'b0, 1'b0, 0); check_state("post_rst");

    for (int b = 0; b < 40; b++) begin
      int nf, n, r;
      promiscuous = ($urandom_range(0, 3) == 0);
      irq_thresh  = 4'($urandom_range(0, 8));
      irq_en      = 1'($urandom);
      if ($urandom_range(0, 2) == 0) cons_write($urandom_range(0, 15));
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        r = $urandom_range(0, 19);
        if (r == 0)                     n = 1;
        else if (r == 1)                n = $urandom_range(2, 5);
        else if (r == 2 && b % 10 == 0) n = 2100;
        else                            n = $urandom_range(6, 80);
        build($urandom_range(0, 3), n);
        send_frame(n, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 15));
      end
      check_state("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
